// File: rtl/idu_pkg.sv
// Decode-stage package: RV32I + Zicsr opcodes, 6-bit ALU op encodings,
// immediate-type enum and a helper that says which opcodes write rd.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [5:0] ALU_NOP   = 6'd0;
  localparam logic [5:0] ALU_ADD   = 6'd1;
  localparam logic [5:0] ALU_SUB   = 6'd2;
  localparam logic [5:0] ALU_SLL   = 6'd3;
  localparam logic [5:0] ALU_SLT   = 6'd4;
  localparam logic [5:0] ALU_SLTU  = 6'd5;
  localparam logic [5:0] ALU_XOR   = 6'd6;
  localparam logic [5:0] ALU_SRL   = 6'd7;
  localparam logic [5:0] ALU_SRA   = 6'd8;
  localparam logic [5:0] ALU_OR    = 6'd9;
  localparam logic [5:0] ALU_AND   = 6'd10;
  localparam logic [5:0] ALU_LUI   = 6'd11;
  localparam logic [5:0] ALU_AUIPC = 6'd12;
  localparam logic [5:0] ALU_JAL   = 6'd13;
  localparam logic [5:0] ALU_JALR  = 6'd14;
  localparam logic [5:0] ALU_BEQ   = 6'd15;
  localparam logic [5:0] ALU_BNE   = 6'd16;
  localparam logic [5:0] ALU_BLT   = 6'd17;
  localparam logic [5:0] ALU_BGE   = 6'd18;
  localparam logic [5:0] ALU_BLTU  = 6'd19;
  localparam logic [5:0] ALU_BGEU  = 6'd20;
  localparam logic [5:0] ALU_LOAD  = 6'd21;
  localparam logic [5:0] ALU_STORE = 6'd22;
  localparam logic [5:0] ALU_CSRRW = 6'd23;
  localparam logic [5:0] ALU_CSRRS = 6'd24;
  localparam logic [5:0] ALU_CSRRC = 6'd25;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_Z
  } imm_type_e;

  function automatic logic is_rd_writer(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD, OPC_SYSTEM: is_rd_writer = 1'b1;
      default:                                 is_rd_writer = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/idu_fwd_mux.sv
// Operand forwarding mux for one source register: the youngest pipeline
// stage holding a matching rd supplies the value; hit_unready flags that
// this stage's result is not yet available (load-use).
module idu_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              rs_addr,
  input  logic                    rs_used,
  input  logic [XLEN-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]      fwd_vld,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic [XLEN-1:0]         fwd_val,
  output logic                    hit_unready
);

  logic found;

  // Scan from youngest to oldest, keep the first hit; x0 always reads zero.
  always_comb begin
    fwd_val     = rf_data;
    hit_unready = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (!found && fwd_vld[k] && (fwd_rd[k*5 +: 5] == rs_addr)) begin
        found       = 1'b1;
        fwd_val     = fwd_data[k*XLEN +: XLEN];
        hit_unready = !fwd_data_ok[k];
      end
    end
    if (rs_addr == 5'd0) begin
      fwd_val     = '0;
      hit_unready = 1'b0;
    end else if (!rs_used) begin
      hit_unready = 1'b0;
    end
  end

endmodule

// File: rtl/idu_fwd_decode.sv
// Decode stage between IFU and EXU: one-entry pipeline register with
// full-throughput ready/valid, N-stage operand forwarding, load-use stall
// and flush on EXU redirect.
// Optional build macro IDU_PERF_CNT_EN adds stall/flush/busy counters.
module idu_fwd_decode
  import idu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int TAG_W   = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic [TAG_W-1:0]        out_tag,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1_rdata,
  input  logic [XLEN-1:0]         rs2_rdata,
  output logic [XLEN-1:0]         rs1_val,
  output logic [XLEN-1:0]         rs2_val,
  output logic [XLEN-1:0]         imm,
  output logic [5:0]              alu_op,
  output logic [4:0]              rd,
  output logic                    rd_wen,
  output logic [11:0]             csr_addr,
  input  logic [NUM_FWD-1:0]      fwd_vld,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    flush
`ifdef IDU_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_flush_cnt,
  output logic [31:0]             perf_busy_cnt
`endif
);

  logic              full;
  logic [31:0]       inst_q;
  logic [XLEN-1:0]   pc_q;
  logic [TAG_W-1:0]  tag_q;
  logic              fire_in;
  logic              fire_out;
  logic              stall;
  logic              use_rs1;
  logic              use_rs2;
  logic              rs1_unready;
  logic              rs2_unready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  imm_type_e         imm_type;
  logic [31:0]       imm32;

  assign opcode   = inst_q[6:0];
  assign funct3   = inst_q[14:12];
  assign rs1_addr = inst_q[19:15];
  assign rs2_addr = inst_q[24:20];
  assign rd       = inst_q[11:7];
  assign csr_addr = inst_q[31:20];
  assign rd_wen   = is_rd_writer(opcode);
  assign out_inst = inst_q;
  assign out_pc   = pc_q;
  assign out_tag  = tag_q;

  assign stall     = full & (rs1_unready | rs2_unready);
  assign out_valid = full & !stall & !flush;
  assign fire_out  = out_valid & out_ready;
  assign in_ready  = !flush & (!full | fire_out);
  assign fire_in   = in_valid & in_ready;

  // Pipeline register: flush wins, a new entry replaces the old one even
  // when it leaves in the same cycle, otherwise a departure empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      full   <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
      tag_q  <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (fire_in) begin
      full   <= 1'b1;
      inst_q <= in_inst;
      pc_q   <= in_pc;
      tag_q  <= in_tag;
    end else if (fire_out) begin
      full <= 1'b0;
    end
  end

  // Opcode decode: ALU op, immediate format and which sources are read.
  always_comb begin
    alu_op   = ALU_NOP;
    imm_type = IMM_NONE;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        alu_op = ALU_LUI;   imm_type = IMM_U; use_rs1 = 1'b0;
      end
      OPC_AUIPC: begin
        alu_op = ALU_AUIPC; imm_type = IMM_U; use_rs1 = 1'b0;
      end
      OPC_JAL: begin
        alu_op = ALU_JAL;   imm_type = IMM_J; use_rs1 = 1'b0;
      end
      OPC_JALR: begin
        alu_op = ALU_JALR;  imm_type = IMM_I;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        use_rs2  = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_BEQ;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          3'b110:  alu_op = ALU_BLTU;
          3'b111:  alu_op = ALU_BGEU;
          default: alu_op = ALU_NOP;
        endcase
      end
      OPC_LOAD: begin
        alu_op = ALU_LOAD;  imm_type = IMM_I;
      end
      OPC_STORE: begin
        alu_op = ALU_STORE; imm_type = IMM_S; use_rs2 = 1'b1;
      end
      OPC_OP, OPC_OP_IMM: begin
        if (opcode == OPC_OP) use_rs2 = 1'b1;
        else                  imm_type = IMM_I;
        case (funct3)
          3'b000:  alu_op = ((opcode == OPC_OP) && inst_q[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = inst_q[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_SYSTEM: begin
        imm_type = funct3[2] ? IMM_Z : IMM_I;
        case (funct3[1:0])
          2'b01:   alu_op = ALU_CSRRW;
          2'b10:   alu_op = ALU_CSRRS;
          2'b11:   alu_op = ALU_CSRRC;
          default: alu_op = ALU_NOP;
        endcase
      end
      default: ;
    endcase
  end

  // Immediate assembly; everything is sign-extended except the CSR zimm.
  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{inst_q[31]}}, inst_q[31:20]};
      IMM_S: imm32 = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      IMM_B: imm32 = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                      inst_q[11:8], 1'b0};
      IMM_U: imm32 = {inst_q[31:12], 12'b0};
      IMM_J: imm32 = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                      inst_q[30:21], 1'b0};
      IMM_Z: imm32 = {27'b0, inst_q[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  idu_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs_addr     (rs1_addr),
    .rs_used     (use_rs1),
    .rf_data     (rs1_rdata),
    .fwd_vld     (fwd_vld),
    .fwd_rd      (fwd_rd),
    .fwd_data_ok (fwd_data_ok),
    .fwd_data    (fwd_data),
    .fwd_val     (rs1_val),
    .hit_unready (rs1_unready)
  );

  idu_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs_addr     (rs2_addr),
    .rs_used     (use_rs2),
    .rf_data     (rs2_rdata),
    .fwd_vld     (fwd_vld),
    .fwd_rd      (fwd_rd),
    .fwd_data_ok (fwd_data_ok),
    .fwd_data    (fwd_data),
    .fwd_val     (rs2_val),
    .hit_unready (rs2_unready)
  );

`ifdef IDU_PERF_CNT_EN
  // Event counters for stall, flush and busy (out_valid) cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_busy_cnt  <= '0;
    end else begin
      if (stall)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush)     perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (out_valid) perf_busy_cnt  <= perf_busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idu_fwd_decode.sv
// Directed bench for idu_fwd_decode: handshake, forwarding, load-use stall,
// flush, back-pressure, reset and immediate decode.
module tb_idu_fwd_decode;
  import idu_pkg::*;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [63:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [63:0] out_tag;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [5:0]  alu_op;
  logic [4:0]  rd;
  logic        rd_wen;
  logic [11:0] csr_addr;
  logic [2:0]  fwd_vld;
  logic [14:0] fwd_rd;
  logic [2:0]  fwd_data_ok;
  logic [95:0] fwd_data;
  logic        flush;
`ifdef IDU_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_busy_cnt;
`endif

  int checks;
  int errors;

  localparam logic [31:0] RF1 = 32'h1111_0001;
  localparam logic [31:0] RF2 = 32'h2222_0002;

  idu_fwd_decode #(.XLEN(32), .NUM_FWD(3), .TAG_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_tag     (out_tag),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_rdata   (rs1_rdata),
    .rs2_rdata   (rs2_rdata),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .imm         (imm),
    .alu_op      (alu_op),
    .rd          (rd),
    .rd_wen      (rd_wen),
    .csr_addr    (csr_addr),
    .fwd_vld     (fwd_vld),
    .fwd_rd      (fwd_rd),
    .fwd_data_ok (fwd_data_ok),
    .fwd_data    (fwd_data),
    .flush       (flush)
`ifdef IDU_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_busy_cnt  (perf_busy_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic v, input logic [4:0] r,
                         input logic ok, input logic [31:0] d);
    fwd_vld[k]          = v;
    fwd_rd[k*5 +: 5]    = r;
    fwd_data_ok[k]      = ok;
    fwd_data[k*32 +: 32] = d;
  endtask

  task automatic clear_fwd();
    fwd_vld     = '0;
    fwd_rd      = '0;
    fwd_data_ok = '0;
    fwd_data    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_tag = '0;
    out_ready = 1'b1; flush = 1'b0; rs1_rdata = RF1; rs2_rdata = RF2;
    clear_fwd();
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %h exp 1", in_ready); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_inst got %h exp 0", out_inst); end
    checks++; if (out_tag !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_tag got %h exp 0", out_tag); end
    cyc();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h100; in_tag = 64'd1;
    set_fwd(0, 1'b1, 5'd1, 1'b1, 32'h1234);
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready0 got %h exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_out_valid0 got %h exp 0", out_valid); end
    cyc();
    in_inst = 32'h0010_8133; in_pc = 32'h104; in_tag = 64'd2;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addi_valid got %h exp 1", out_valid); end
    checks++; if (out_inst !== 32'h0050_0093) begin errors++; $display("[TB] FAIL b2b_addi_inst got %h exp 00500093", out_inst); end
    checks++; if (imm !== 32'd5) begin errors++; $display("[TB] FAIL b2b_addi_imm got %h exp 5", imm); end
    checks++; if (alu_op !== ALU_ADD || rd !== 5'd1 || rd_wen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_addi_dec got op %0d rd %0d wen %0d exp %0d 1 1", alu_op, rd, rd_wen, ALU_ADD); end
    checks++; if (rs1_val !== 32'h0) begin errors++; $display("[TB] FAIL b2b_addi_x0 got %h exp 0", rs1_val); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready1 got %h exp 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_8133 || out_pc !== 32'h104) begin errors++; $display("[TB] FAIL b2b_add_out got v %h inst %h pc %h exp 1 00108133 104", out_valid, out_inst, out_pc); end
    checks++; if (rs1_val !== 32'h1234 || rs2_val !== 32'h1234) begin errors++; $display("[TB] FAIL b2b_add_fwd got %h %h exp 1234 1234", rs1_val, rs2_val); end
    checks++; if (alu_op !== ALU_ADD || rd !== 5'd2) begin errors++; $display("[TB] FAIL b2b_add_dec got op %0d rd %0d exp %0d 2", alu_op, rd, ALU_ADD); end
    cyc();
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain got %h exp 0", out_valid); end
    cyc();
    clear_fwd();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; in_inst = 32'h0000_2283; in_pc = 32'h200; in_tag = 64'd3;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'h0);
    cyc();
    in_inst = 32'h0002_8333; in_pc = 32'h204; in_tag = 64'd4;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || alu_op !== ALU_LOAD) begin errors++; $display("[TB] FAIL lu_lw_out got v %h op %0d exp 1 %0d", out_valid, alu_op, ALU_LOAD); end
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_valid got %h exp 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_ready got %h exp 0", in_ready); end
      cyc();
    end
    set_fwd(0, 1'b1, 5'd5, 1'b1, 32'hCAFE_F00D);
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0002_8333) begin errors++; $display("[TB] FAIL lu_release got v %h inst %h exp 1 00028333", out_valid, out_inst); end
    checks++; if (rs1_val !== 32'hCAFE_F00D || rs2_val !== 32'h0) begin errors++; $display("[TB] FAIL lu_value got %h %h exp cafef00d 0", rs1_val, rs2_val); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL lu_ready got %h exp 1", in_ready); end
    cyc();
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_drain got %h exp 0", out_valid); end
    cyc();
    clear_fwd();
  endtask

  task automatic test_priority();
    in_valid = 1'b1; in_inst = 32'h0003_8433; in_pc = 32'h300; in_tag = 64'd5;
    out_ready = 1'b0;
    set_fwd(0, 1'b1, 5'd7, 1'b1, 32'hAA);
    set_fwd(2, 1'b1, 5'd7, 1'b0, 32'hBB);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (rs1_addr !== 5'd7) begin errors++; $display("[TB] FAIL pri_rs1_addr got %0d exp 7", rs1_addr); end
    checks++; if (rs1_val !== 32'hAA || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pri_youngest got %h v %h exp aa 1", rs1_val, out_valid); end
    set_fwd(0, 1'b0, 5'd7, 1'b1, 32'hAA);
    #1;
    checks++; if (rs1_val !== 32'hBB || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pri_oldest got %h v %h exp bb 0", rs1_val, out_valid); end
    set_fwd(2, 1'b0, 5'd7, 1'b1, 32'hBB);
    #1;
    checks++; if (rs1_val !== RF1 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pri_regfile got %h v %h exp %h 1", rs1_val, out_valid, RF1); end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b1; in_inst = 32'h0000_04B3; in_pc = 32'h304; in_tag = 64'd6;
    for (int k = 0; k < 3; k++) set_fwd(k, 1'b1, 5'd0, 1'b0, 32'h55);
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (rs1_val !== 32'h0 || rs2_val !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pri_x0 got %h %h v %h exp 0 0 1", rs1_val, rs2_val, out_valid); end
    cyc();
    clear_fwd();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h400; in_tag = 64'd7;
    out_ready = 1'b1;
    cyc();
    flush = 1'b1; in_inst = 32'h0000_04B3; in_pc = 32'h404;
    @(negedge clock);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready got %h exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid got %h exp 0", out_valid); end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_next_valid got %h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_ready got %h exp 1", in_ready); end
    cyc();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_inst = 32'h0010_8133; in_pc = 32'h500; in_tag = 64'hA5A5_0000_1234_5678;
    out_ready = 1'b0;
    cyc();
    in_inst = 32'h0050_0093; in_pc = 32'h504; in_tag = 64'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0010_8133 || out_pc !== 32'h500 || out_tag !== 64'hA5A5_0000_1234_5678) begin errors++; $display("[TB] FAIL bp_hold got v %h inst %h pc %h tag %h exp 1 00108133 500 a5a5000012345678", out_valid, out_inst, out_pc, out_tag); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %h exp 0", in_ready); end
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %h exp 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0050_0093 || out_pc !== 32'h504 || out_tag !== 64'd9) begin errors++; $display("[TB] FAIL bp_next got v %h inst %h pc %h tag %h exp 1 00500093 504 9", out_valid, out_inst, out_pc, out_tag); end
    cyc();
  endtask

  task automatic test_decode();
    logic [31:0] d_inst [9];
    logic [31:0] d_imm  [9];
    logic [5:0]  d_op   [9];
    logic        d_wen  [9];
    d_inst[0] = 32'hFE20_AE23; d_imm[0] = 32'hFFFF_FFFC; d_op[0] = ALU_STORE; d_wen[0] = 1'b0;
    d_inst[1] = 32'h1234_51B7; d_imm[1] = 32'h1234_5000; d_op[1] = ALU_LUI;   d_wen[1] = 1'b1;
    d_inst[2] = 32'hFE20_8CE3; d_imm[2] = 32'hFFFF_FFF8; d_op[2] = ALU_BEQ;   d_wen[2] = 1'b0;
    d_inst[3] = 32'h0010_00EF; d_imm[3] = 32'h0000_0800; d_op[3] = ALU_JAL;   d_wen[3] = 1'b1;
    d_inst[4] = 32'h3001_10F3; d_imm[4] = 32'h0000_0300; d_op[4] = ALU_CSRRW; d_wen[4] = 1'b1;
    d_inst[5] = 32'h3002_D0F3; d_imm[5] = 32'h0000_0005; d_op[5] = ALU_CSRRW; d_wen[5] = 1'b1;
    d_inst[6] = 32'h0000_007F; d_imm[6] = 32'h0000_0000; d_op[6] = ALU_NOP;   d_wen[6] = 1'b0;
    d_inst[7] = 32'h4020_81B3; d_imm[7] = 32'h0000_0000; d_op[7] = ALU_SUB;   d_wen[7] = 1'b1;
    d_inst[8] = 32'h4030_D093; d_imm[8] = 32'h0000_0403; d_op[8] = ALU_SRA;   d_wen[8] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_inst = d_inst[i]; in_pc = 32'h600 + 32'(i * 4); in_tag = 64'(i);
      cyc();
      in_valid = 1'b0;
      @(negedge clock);
      checks++; if (imm !== d_imm[i] || alu_op !== d_op[i] || rd_wen !== d_wen[i] || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dec_%0d got imm %h op %0d wen %0d v %0d exp %h %0d %0d 1", i, imm, alu_op, rd_wen, out_valid, d_imm[i], d_op[i], d_wen[i]); end
      if (i == 4) begin
        checks++; if (csr_addr !== 12'h300) begin errors++; $display("[TB] FAIL dec_csr_addr got %h exp 300", csr_addr); end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_inst = 32'h0010_8133; in_pc = 32'h700; in_tag = 64'd11;
    out_ready = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rm_full got %h exp 1", out_valid); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("[TB] FAIL rm_cleared got v %h pc %h inst %h exp 0 0 0", out_valid, out_pc, out_inst); end
`ifdef IDU_PERF_CNT_EN
    checks++; if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0 || perf_busy_cnt !== 32'h0) begin errors++; $display("[TB] FAIL rm_perf got %h %h %h exp 0 0 0", perf_stall_cnt, perf_flush_cnt, perf_busy_cnt); end
`endif
    cyc();
  endtask

`ifdef IDU_PERF_CNT_EN
  task automatic test_perf();
    in_valid = 1'b1; in_inst = 32'h0002_8333; in_pc = 32'h800; in_tag = 64'd12;
    out_ready = 1'b1;
    set_fwd(0, 1'b1, 5'd5, 1'b0, 32'h0);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0050_0093;
    clear_fwd();
    cyc();
    in_valid = 1'b0;
    cyc();
    @(negedge clock);
    checks++; if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd1 || perf_busy_cnt !== 32'd1) begin errors++; $display("[TB] FAIL perf_counts got %0d %0d %0d exp 3 1 1", perf_stall_cnt, perf_flush_cnt, perf_busy_cnt); end
    cyc();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_flush();
    test_backpressure();
    test_decode();
    test_reset_mid();
`ifdef IDU_PERF_CNT_EN
    test_reset();
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
